// File: rtl/inst_mem_responder.sv
// Instruction-bus slave that serves reads from a synchronous single-port SRAM.
// It inserts WAIT_STATES cycles before each SRAM access and faults misaligned or
// out-of-range addresses. A one-entry response buffer lets a repeated read of
// the same word complete with zero wait.
//
// Ports:
//   i_clock, i_reset  clock (rising edge) and asynchronous active-low reset
//   i_addr, i_re      bus byte address and read request
//   o_inst, o_busy    read data; valid when i_re=1 and o_busy=0
//   o_fault           qualifies o_inst: the access faulted
//   i_flush           one-cycle pulse that invalidates the response buffer
//   o_mem_en          registered SRAM read enable
//   o_mem_addr        registered SRAM word index
//   i_mem_rdata       SRAM read data, one cycle after o_mem_en
module inst_mem_responder #(
  parameter int unsigned                ADDR_WIDTH  = 32,
  parameter int unsigned                DATA_WIDTH  = 32,
  parameter int unsigned                DEPTH_LOG2  = 12,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR   = '0,
  parameter int unsigned                WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0]      FAULT_INST  = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_re,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic                  o_busy,
  output logic                  o_fault,
  input  logic                  i_flush,
  output logic                  o_mem_en,
  output logic [DEPTH_LOG2-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StWait, StIssue, StCapt} state_e;

  // One extra bit so BASE_ADDR + size cannot wrap.
  localparam logic [ADDR_WIDTH:0] BaseExt  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LimitExt =
      BaseExt + ((ADDR_WIDTH+1)'(1) << (DEPTH_LOG2 + 2));

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic                  buf_fault_q, buf_fault_d;
  logic                  mem_en_q, mem_en_d;
  logic [DEPTH_LOG2-1:0] mem_addr_q, mem_addr_d;

  logic                  hit;
  logic                  addr_fault;
  logic [ADDR_WIDTH:0]   addr_ext;

  assign addr_ext   = {1'b0, i_addr};
  assign addr_fault = (|i_addr[1:0]) || (addr_ext < BaseExt) || (addr_ext >= LimitExt);
  assign hit        = buf_valid_q && (buf_addr_q == i_addr);

  assign o_busy     = i_re && !((state_q == StIdle) && hit);
  assign o_inst     = buf_data_q;
  assign o_fault    = i_re && !o_busy && buf_fault_q;
  assign o_mem_en   = mem_en_q;
  assign o_mem_addr = mem_addr_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_addr_d  = buf_addr_q;
    buf_fault_d = buf_fault_q;
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr_q;

    unique case (state_q)
      StIdle: begin
        if (i_re && !hit) begin
          req_addr_d = i_addr;
          if (addr_fault) begin
            // Faults are answered from the buffer without touching the SRAM.
            buf_data_d  = FAULT_INST;
            buf_fault_d = 1'b1;
            buf_addr_d  = i_addr;
            buf_valid_d = 1'b1;
          end else if (WAIT_STATES > 0) begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = StWait;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StIssue;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StIssue: begin
        state_d = StCapt;
      end
      StCapt: begin
        buf_data_d  = i_mem_rdata;
        buf_addr_d  = req_addr_q;
        buf_fault_d = 1'b0;
        buf_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // SRAM strobe is registered on entry to ISSUE so it is high during ISSUE.
    if ((state_d == StIssue) && (state_q != StIssue)) begin
      mem_en_d   = 1'b1;
      mem_addr_d = DEPTH_LOG2'((req_addr_d - BASE_ADDR) >> 2);
    end

    // Flush beats any simultaneous fill; a pending request then misses again.
    if (i_flush) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_addr_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_addr_q  <= '0;
      buf_fault_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_addr_q  <= buf_addr_d;
      buf_fault_q <= buf_fault_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;

  localparam logic [31:0] FaultWord = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, addr0 = '0;
  logic        re = 1'b0, re0 = 1'b0, flush = 1'b0;
  logic [31:0] inst, inst0, rdata, rdata0;
  logic        busy, busy0, fault, fault0, mem_en, mem_en0;
  logic [11:0] mem_addr, mem_addr0;

  logic [31:0] mem [4096];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_mem_responder #(
    .WAIT_STATES(2),
    .FAULT_INST (FaultWord)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_addr     (addr),
    .i_re       (re),
    .o_inst     (inst),
    .o_busy     (busy),
    .o_fault    (fault),
    .i_flush    (flush),
    .o_mem_en   (mem_en),
    .o_mem_addr (mem_addr),
    .i_mem_rdata(rdata)
  );

  inst_mem_responder #(
    .WAIT_STATES(0),
    .FAULT_INST (FaultWord)
  ) dut0 (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_addr     (addr0),
    .i_re       (re0),
    .o_inst     (inst0),
    .o_busy     (busy0),
    .o_fault    (fault0),
    .i_flush    (1'b0),
    .o_mem_en   (mem_en0),
    .o_mem_addr (mem_addr0),
    .i_mem_rdata(rdata0)
  );

  // Synchronous SRAM models sharing one image.
  always @(posedge clk) begin
    if (mem_en)  rdata  <= mem[mem_addr];
    if (mem_en0) rdata0 <= mem[mem_addr0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full miss on the WAIT_STATES=2 instance: busy cycles 0..4, data in cycle 5.
  task automatic miss(input string tag, input logic [31:0] a, input logic [11:0] idx,
                      input logic [31:0] d);
    re   = 1'b1;
    addr = a;
    #1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick();
      chk({tag, "_busy"}, 32'(busy), 32'(c < 5));
      chk({tag, "_mem_en"}, 32'(mem_en), 32'(c == 3));
      if (c == 3) chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(idx));
      if (c == 5) begin
        chk({tag, "_inst"}, inst, d);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + 32'(i) * 3;
    mem[4] = 32'h0130_0093;

    // Reset state; busy follows i_re while in reset.
    re = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_inst", inst, 32'd0);
    re = 1'b0;
    #1;
    chk("rst_busy_idle", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // First miss, then an immediate repeat hit, then the next word.
    miss("m10", 32'h10, 12'd4, 32'h0130_0093);
    tick();
    chk("hit10_busy", 32'(busy), 32'd0);
    chk("hit10_mem_en", 32'(mem_en), 32'd0);
    chk("hit10_inst", inst, 32'h0130_0093);
    miss("m14", 32'h14, 12'd5, 32'h1000_000F);

    // Misaligned and out-of-range: one busy cycle, then the fault word.
    addr = 32'h12;
    #1;
    chk("mis_busy0", 32'(busy), 32'd1);
    tick();
    chk("mis_busy1", 32'(busy), 32'd0);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_inst", inst, FaultWord);
    chk("mis_mem_en", 32'(mem_en), 32'd0);
    addr = 32'h4000;
    #1;
    chk("oor_busy0", 32'(busy), 32'd1);
    tick();
    chk("oor_busy1", 32'(busy), 32'd0);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_inst", inst, FaultWord);
    chk("oor_mem_en", 32'(mem_en), 32'd0);

    // Last word in range is a normal miss.
    miss("mtop", 32'h3FFC, 12'hFFF, 32'h1000_2FFD);

    // Flush after a hit forces a refetch.
    miss("m10b", 32'h10, 12'd4, 32'h0130_0093);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    miss("m10f", 32'h10, 12'd4, 32'h0130_0093);

    // Flush coincident with CAPT: buffer stays invalid, request refetched.
    addr = 32'h14;
    #1;
    chk("fc_busy0", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("fc_busy4", 32'(busy), 32'd1);
    tick();
    flush = 1'b0;
    miss("fc_refetch", 32'h14, 12'd5, 32'h1000_000F);

    // Zero wait states: busy cycles 0..2, SRAM strobe in cycle 1, data in cycle 3.
    re0   = 1'b1;
    addr0 = 32'h10;
    #1;
    chk("ws0_busy0", 32'(busy0), 32'd1);
    chk("ws0_en0", 32'(mem_en0), 32'd0);
    tick();
    chk("ws0_busy1", 32'(busy0), 32'd1);
    chk("ws0_en1", 32'(mem_en0), 32'd1);
    chk("ws0_addr1", 32'(mem_addr0), 32'd4);
    tick();
    chk("ws0_busy2", 32'(busy0), 32'd1);
    chk("ws0_en2", 32'(mem_en0), 32'd0);
    tick();
    chk("ws0_busy3", 32'(busy0), 32'd0);
    chk("ws0_inst", inst0, 32'h0130_0093);
    chk("ws0_fault", 32'(fault0), 32'd0);
    re0 = 1'b0;

    // Reset during WAIT abandons the fetch and empties the buffer.
    addr = 32'h18;
    tick();
    chk("rw_busy1", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_mem_en", 32'(mem_en), 32'd0);
    chk("rw_busy", 32'(busy), 32'd1);
    chk("rw_fault", 32'(fault), 32'd0);
    tick();
    chk("rw_mem_en2", 32'(mem_en), 32'd0);
    rst_n = 1'b1;
    miss("rw_m14", 32'h14, 12'd5, 32'h1000_000F);

    // Dropping i_re mid-fetch still fills the buffer.
    addr = 32'h20;
    #1;
    chk("drop_busy0", 32'(busy), 32'd1);
    tick();
    re = 1'b0;
    #1;
    chk("drop_busy1", 32'(busy), 32'd0);
    tick();
    tick();
    chk("drop_mem_en", 32'(mem_en), 32'd1);
    chk("drop_mem_addr", 32'(mem_addr), 32'd8);
    tick();
    tick();
    re = 1'b1;
    #1;
    chk("drop_hit_busy", 32'(busy), 32'd0);
    chk("drop_hit_inst", inst, 32'h1000_0018);

    // Address changed mid-fetch: the new address misses once back in IDLE.
    addr = 32'h24;
    #1;
    tick();
    addr = 32'h28;
    tick();
    tick();
    tick();
    tick();
    chk("chg_busy5", 32'(busy), 32'd1);
    miss("chg_m28", 32'h28, 12'd10, 32'h1000_001E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
